imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Writer side of the CPU instruction memory. It receives a byte-serial program image over a valid/ready stream and assembles big-endian 32-bit words. Each word is written into instruction memory at consecutive word addresses. The CPU is held in reset-hold (cpu_hold) until a complete, checksum-verified image has been written; the instruction-fetch stage then reads from word 0 as usual.

Parameters:
ADDR_WIDTH, 8, word-address width of instruction memory (256 words)
MAX_WORDS, 256, largest legal image word count; must be <= 2**ADDR_WIDTH

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a load; ignored while busy
byte_valid  input  1  byte_data is valid
byte_data  input  8  image stream byte
byte_ready  output  1  loader accepts byte this cycle (transfer = byte_valid & byte_ready)
mem_we  output  1  one-cycle instruction-memory write strobe
mem_addr  output  ADDR_WIDTH  word address of write
mem_wdata  output  32  word to write
cpu_hold  output  1  keeps PC and pipeline registers in reset while high
done  output  1  sticky; image loaded and checksum matched
error  output  1  sticky; oversize count or checksum mismatch
words_loaded  output  ADDR_WIDTH+1  number of words written in current load

Behaviour:
- Reset: already decided, reset asynchronous, active-high, clock clk. Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0, state IDLE. Reset mid-load aborts immediately; the partial memory contents are not cleared.
- Stream format: CNT_HI, CNT_LO (16-bit word count N, big-endian), then 4*N payload bytes (MSB first per word), then CK. CK is the XOR of all preceding bytes, including the count bytes.
- All outputs are registered.
- IDLE: byte_ready=0. On start: go to HDR_HI, set cpu_hold=1, clear done/error/words_loaded/running XOR.
- HDR_HI / HDR_LO: byte_ready=1; each accepted byte is latched and XORed into the running checksum.
- After HDR_LO:
  - N > MAX_WORDS: go to ERROR; no writes occur.
  - N == 0: go to CKSUM.
  - Otherwise: go to DATA.
- DATA: byte_ready=1. Shift each accepted byte into the word register (byte 0 lands in bits 31:24). After the 4th byte go to WRITE.
- WRITE: lasts exactly one cycle.
  - mem_we=1, mem_addr=word index, mem_wdata=assembled word; byte_ready=0.
  - words_loaded increments.
  - Next state is CKSUM if words_loaded reaches N, else DATA.
  - Write latency: mem_we asserts in the cycle after the 4th byte is accepted.
- CKSUM: byte_ready=1. On the accepted byte:
  - CK == running XOR: go to DONE.
  - Otherwise: go to ERROR.
- DONE: done=1. cpu_hold=0 starting in the cycle after the CK transfer.
- ERROR: error=1, cpu_hold stays 1. Writes already made are left in memory.
- byte_valid low in any receiving state: stall with no state change; no timeout.
- start in DONE or ERROR restarts the load (cpu_hold=1 the next cycle). start in any other state is ignored.
- A start in the same cycle as a CK transfer is ignored.
- mem_addr wraps at 2**ADDR_WIDTH; this is unreachable because N <= MAX_WORDS.

Decomposition:
- Shared package (cpu_pkg): loader state enum {IDLE, HDR_HI, HDR_LO, DATA, WRITE, CKSUM, DONE, ERROR} and the IMEM_DEPTH constant. IMEM_DEPTH is shared with the instruction memory.
- One sub-module: imem_word_assembler. It contains the 4-byte shift register plus the byte counter 0..3, exposes word_full, and is cleared on start/reset.

Test Plan:
- Reset asserted mid-cycle -> immediately cpu_hold=1, byte_ready=0, mem_we=0, done=0, error=0, words_loaded=0.
- start, then stream 00 02 DE AD BE EF 12 34 56 78 28 -> two write pulses: addr 0 data 0xDEADBEEF, then addr 1 data 0x12345678, each the cycle after the 4th byte. Then done=1, cpu_hold=0, error=0, words_loaded=2.
- Same stream with CK=0x29 -> both writes occur; then error=1, done=0, cpu_hold stays 1. A new start followed by the correct stream yields done=1.
- Count bytes 01 01 (257) -> error=1 the cycle after CNT_LO, no mem_we ever. Stream 00 00 00 -> done=1 with no writes.
- Random byte_valid gaps during the 2-word load -> identical writes and result. byte_ready=0 in each WRITE cycle; a byte offered then is held and accepted the next cycle, not lost or duplicated.
- reset pulse after 5 bytes of a load -> all outputs at reset values. Then start plus a full valid image completes with done=1 and correct writes.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction-memory depth and the image loader FSM states.
package cpu_pkg;

  localparam int IMEM_DEPTH = 256;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    CKSUM,
    DONE,
    ERROR
  } loader_state_e;

endpackage

// File: rtl/imem_word_assembler.sv
// Collects big-endian bytes into a 32-bit word; word_full flags the byte that completes it.
module imem_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic        word_full,
  output logic [31:0] word_next
);

  // Only the first three bytes are stored; the fourth completes word_next
  // combinationally so the caller can register the write in the same edge.
  logic [23:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  assign word_next = {word_q, byte_in};
  assign word_full = shift_en && (cnt_q == 2'd3);

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      word_d = word_next[23:0];
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte-serial, checksummed program image into instruction memory and
// releases cpu_hold only once the whole image has been written and verified.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = IMEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);
  localparam logic [ADDR_WIDTH:0] WL_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  loader_state_e state_q, state_d;
  logic [7:0]  cnt_hi_q, cnt_hi_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  xor_q, xor_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH:0]   words_loaded_q, words_loaded_d;

  logic        xfer, restart, word_full;
  logic [31:0] word_next;
  logic [15:0] hdr_count;

  assign xfer      = byte_valid & byte_ready_q;
  assign restart   = start && (state_q == IDLE || state_q == DONE || state_q == ERROR);
  assign hdr_count = {cnt_hi_q, byte_data};

  imem_word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (restart),
    .shift_en  (xfer && (state_q == DATA)),
    .byte_in   (byte_data),
    .word_full (word_full),
    .word_next (word_next)
  );

  always_comb begin
    state_d        = state_q;
    cnt_hi_d       = cnt_hi_q;
    count_d        = count_q;
    xor_d          = xor_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    cpu_hold_d     = cpu_hold_q;
    done_d         = done_q;
    error_d        = error_q;
    words_loaded_d = words_loaded_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d        = HDR_HI;
          cpu_hold_d     = 1'b1;
          done_d         = 1'b0;
          error_d        = 1'b0;
          words_loaded_d = '0;
          xor_d          = '0;
        end
      end
      HDR_HI: if (xfer) begin
        cnt_hi_d = byte_data;
        xor_d    = xor_q ^ byte_data;
        state_d  = HDR_LO;
      end
      HDR_LO: if (xfer) begin
        count_d = hdr_count;
        xor_d   = xor_q ^ byte_data;
        if ({1'b0, hdr_count} > MAX_W) begin
          state_d = ERROR;
          error_d = 1'b1;
        end else if (hdr_count == 16'd0) begin
          state_d = CKSUM;
        end else begin
          state_d = DATA;
        end
      end
      DATA: if (xfer) begin
        xor_d = xor_q ^ byte_data;
        if (word_full) begin
          state_d        = WRITE;
          mem_we_d       = 1'b1;
          mem_addr_d     = words_loaded_q[ADDR_WIDTH-1:0];
          mem_wdata_d    = word_next;
          words_loaded_d = words_loaded_q + WL_ONE;
        end
      end
      // words_loaded already counts the word being written this cycle
      WRITE: state_d = (16'(words_loaded_q) == count_q) ? CKSUM : DATA;
      CKSUM: if (xfer) begin
        if (byte_data == xor_q) begin
          state_d    = DONE;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
        end else begin
          state_d = ERROR;
          error_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    byte_ready_d = (state_d == HDR_HI) || (state_d == HDR_LO) ||
                   (state_d == DATA)   || (state_d == CKSUM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_hi_q       <= '0;
      count_q        <= '0;
      xor_q          <= '0;
      byte_ready_q   <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      cpu_hold_q     <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_hi_q       <= cnt_hi_d;
      count_q        <= count_d;
      xor_q          <= xor_d;
      byte_ready_q   <= byte_ready_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      cpu_hold_q     <= cpu_hold_d;
      done_q         <= done_d;
      error_q        <= error_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  assign byte_ready   = byte_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, corner sequences and
// randomized images checked against an image-level reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  imem_loader #(.ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t wr_q[$];
  logic [7:0] img[$];

  typedef struct {
    logic [87:0] bytes;
    int          len;
    bit          exp_done;
    bit          exp_err;
    int          exp_words;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && mem_we === 1'b1) begin
      wr_q.push_back({mem_addr, mem_wdata});
      chk("ready_low_in_write", {31'b0, byte_ready}, 32'd0);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    bit took;
    for (int g = 0; g < 4 && int'($urandom_range(99)) < gap_pct; g++) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    took = 1'b0;
    for (int c = 0; c < 200 && !took; c++) begin
      @(negedge clk);
      took = byte_ready;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    if (!took) begin
      checks++;
      failures++;
      $display("FAIL byte_accept_timeout actual=not_accepted required=accepted byte=%h", b);
    end
  endtask

  task automatic load(input int gap_pct);
    wr_q.delete();
    pulse_start();
    foreach (img[i]) send_byte(img[i], gap_pct);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Reference: outcome derived from the image bytes alone.
  task automatic check_model(input string tag, input bit do_flags);
    int n, nw;
    bit err;
    logic [7:0] x;
    n = {img[0], img[1]};
    if (n > 256) begin
      err = 1'b1;
      nw  = 0;
    end else begin
      nw = n;
      x  = 8'h00;
      for (int i = 0; i < img.size() - 1; i++) x ^= img[i];
      err = (x != img[img.size() - 1]);
    end
    if (do_flags) begin
      chk({tag, "_done"}, {31'b0, done}, {31'b0, !err});
      chk({tag, "_error"}, {31'b0, error}, {31'b0, err});
      chk({tag, "_hold"}, {31'b0, cpu_hold}, {31'b0, err});
      chk({tag, "_words"}, {23'b0, words_loaded}, nw);
    end
    chk({tag, "_nwrites"}, wr_q.size(), nw);
    for (int i = 0; i < nw && i < wr_q.size(); i++) begin
      chk({tag, "_addr"}, {24'b0, wr_q[i].a}, i);
      chk({tag, "_data"}, wr_q[i].d,
          {img[2+4*i], img[3+4*i], img[4+4*i], img[5+4*i]});
    end
  endtask

  task automatic set_img_from_vec(input vec_t v);
    img.delete();
    for (int i = 0; i < v.len; i++) img.push_back(v.bytes[87-8*i -: 8]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, gap;
    logic [7:0] ck;
    logic [15:0] nn;
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

    vecs[0] = '{88'h0002DEADBEEF1234567828, 11, 1'b1, 1'b0, 2};
    vecs[1] = '{88'h0002DEADBEEF1234567829, 11, 1'b0, 1'b1, 2};
    vecs[2] = '{88'h0002DEADBEEF1234567828, 11, 1'b1, 1'b0, 2};
    vecs[3] = '{{16'h0101, 72'h0},            2, 1'b0, 1'b1, 0};
    vecs[4] = '{{24'h000000, 64'h0},          3, 1'b1, 1'b0, 0};
    vecs[5] = '{{56'h00011122334445, 32'h0},  7, 1'b1, 1'b0, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, byte_ready}, 0);
    chk("rst_we", {31'b0, mem_we}, 0);
    chk("rst_addr", {24'b0, mem_addr}, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_hold", {31'b0, cpu_hold}, 1);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_error", {31'b0, error}, 0);
    chk("rst_words", {23'b0, words_loaded}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      set_img_from_vec(vecs[v]);
      load((v % 2) * 40);
      chk("vec_done", {31'b0, done}, {31'b0, vecs[v].exp_done});
      chk("vec_error", {31'b0, error}, {31'b0, vecs[v].exp_err});
      chk("vec_hold", {31'b0, cpu_hold}, {31'b0, vecs[v].exp_err});
      chk("vec_words", {23'b0, words_loaded}, vecs[v].exp_words);
      check_model("vec", 1'b0);
    end

    // Write latency, byte held across WRITE, start coincident with CK ignored.
    img = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    wr_q.delete();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(img[i], 0);
    chk("lat_we", {31'b0, mem_we}, 1);
    chk("lat_ready", {31'b0, byte_ready}, 0);
    chk("lat_wdata", mem_wdata, 32'h11223344);
    byte_valid = 1'b1;
    byte_data  = 8'h45;
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    chk("ck_ready", {31'b0, byte_ready}, 1);
    @(posedge clk); #1;
    start = 1'b0;
    byte_valid = 1'b0;
    chk("ck_done", {31'b0, done}, 1);
    chk("ck_hold_released", {31'b0, cpu_hold}, 0);
    @(posedge clk); #1;
    chk("ck_start_ignored", {31'b0, done}, 1);
    check_model("held", 1'b1);

    // Oversize count flags error the cycle after CNT_LO, with no writes.
    img = '{8'h01, 8'h01};
    wr_q.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    chk("ovf_error_next", {31'b0, error}, 1);
    chk("ovf_ready", {31'b0, byte_ready}, 0);
    repeat (3) @(posedge clk);
    #1;
    check_model("ovf", 1'b1);

    // start while busy is ignored.
    img = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h00};
    ck = 8'h00;
    for (int i = 0; i < 6; i++) ck ^= img[i];
    img[6] = ck;
    wr_q.delete();
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(img[i], 0);
    pulse_start();
    for (int i = 3; i < 7; i++) send_byte(img[i], 0);
    repeat (2) @(posedge clk);
    #1;
    check_model("busy_start", 1'b1);

    // Reset after 5 bytes aborts; a fresh load afterwards completes.
    set_img_from_vec(vecs[0]);
    wr_q.delete();
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(img[i], 0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_hold", {31'b0, cpu_hold}, 1);
    chk("mid_rst_ready", {31'b0, byte_ready}, 0);
    chk("mid_rst_we", {31'b0, mem_we}, 0);
    chk("mid_rst_done", {31'b0, done}, 0);
    chk("mid_rst_error", {31'b0, error}, 0);
    chk("mid_rst_words", {23'b0, words_loaded}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    load(30);
    check_model("after_rst", 1'b1);

    for (int r = 0; r < 25; r++) begin
      img.delete();
      if ($urandom_range(9) == 0) begin
        nn = 16'($urandom_range(65535, 257));
        img.push_back(nn[15:8]);
        img.push_back(nn[7:0]);
      end else begin
        n  = $urandom_range(4);
        nn = 16'(n);
        img.push_back(nn[15:8]);
        img.push_back(nn[7:0]);
        for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
        ck = 8'h00;
        foreach (img[i]) ck ^= img[i];
        if ($urandom_range(3) == 0) ck ^= 8'(1 << $urandom_range(7));
        img.push_back(ck);
      end
      gap = $urandom_range(60);
      load(gap);
      check_model("rand", 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
